cv32e40p_nmr_voter_ctrl: RTL and testbench
==========================================

CV32E40P_NMR_VOTER_CTRL -- requirements
Module: cv32e40p_nmr_voter_ctrl

Interface
REQ-001 SHALL have parameter N_REP, default 3, meaning replica count; only 3 and 5 are legal, and elaboration SHALL fail otherwise.
REQ-002 SHALL have parameter WIDTH, default 32, meaning voted bus width.
REQ-003 SHALL have parameters INCREMENT=3, DECREMENT=1, BREAKING_THRESHOLD=12 and COUNT_BIT=5, meaning breakage-counter arithmetic.
REQ-004 The block has one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all state updating on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port valid_i, input, 1 bit: rep_data_i is meaningful this cycle.
REQ-008 SHALL have port rep_data_i, input, N_REP x WIDTH: replica outputs to vote.
REQ-009 SHALL have port set_broken_i, input, N_REP bits: force the replica broken.
REQ-010 SHALL have port clr_broken_i, input, N_REP bits: restore the replica and zero its counter.
REQ-011 SHALL have port voted_o, output, WIDTH: registered voted value.
REQ-012 SHALL have port valid_o, output, 1 bit: valid_i delayed by one cycle.
REQ-013 SHALL have port err_detected_o, output, 1 bit: a healthy replica disagreed.
REQ-014 SHALL have port err_corrected_o, output, 1 bit: the disagreement was masked by majority.
REQ-015 SHALL have port uncorrectable_o, output, 1 bit: no majority, DUPLEX mismatch, or FAILED.
REQ-016 SHALL have port is_broken_o, output, N_REP bits: per-replica broken flags.
REQ-017 SHALL have port mode_o, output, 2 bits: 0 NMR, 1 DUPLEX, 2 SIMPLEX, 3 FAILED.
REQ-018 SHALL have port err_count_o, output, 16 bits: saturating count of err_detected events.

Function
REQ-019 The healthy set SHALL be the replicas with is_broken_o low; H SHALL be its popcount.
REQ-020 mode_o SHALL be combinational from H: H>=3 gives NMR, H=2 DUPLEX, H=1 SIMPLEX, H=0 FAILED.
REQ-021 In NMR, the voted value SHALL be the value held by more than H/2 healthy replicas; with no such value, the block SHALL output the lowest-index healthy replica and assert uncorrectable.
REQ-022 In DUPLEX, the block SHALL output the lower-index healthy replica; on mismatch it SHALL assert err_detected and uncorrectable, and SHALL NOT blame either replica.
REQ-023 In SIMPLEX, the block SHALL pass the healthy replica through with no error detection.
REQ-024 In FAILED, voted_o SHALL be 0 and uncorrectable SHALL be 1 whenever valid.
REQ-025 The outputs voted_o, valid_o, err_detected_o, err_corrected_o and uncorrectable_o SHALL be registered with a latency of exactly 1 cycle.
REQ-026 These outputs SHALL update only when valid_i=1, except valid_o, which SHALL follow valid_i every cycle.
REQ-027 The flags err_detected, err_corrected and uncorrectable SHALL be 0 in any cycle after valid_i=0.
REQ-028 err_corrected SHALL be 1 only when a majority exists and at least one healthy replica differs from it.
REQ-029 Per-replica blame: in NMR with a majority, a healthy replica differing from the voted value is blamed.
REQ-030 A blamed replica's counter SHALL add INCREMENT, saturating at 2^COUNT_BIT-1.
REQ-031 A healthy replica that is not blamed, on a valid cycle, SHALL subtract DECREMENT, saturating at 0.
REQ-032 Breakage counters SHALL hold on invalid cycles.
REQ-033 is_broken_o[k] SHALL rise in the cycle after the counter reaches BREAKING_THRESHOLD or set_broken_i[k]=1, and SHALL be sticky.
REQ-034 A broken replica's counter SHALL freeze.
REQ-035 clr_broken_i[k] SHALL zero the counter and clear is_broken_o[k] on the next edge; clr SHALL have priority over set and over increment in the same cycle.
REQ-036 Mode changes caused by a new broken flag SHALL apply to the vote on the next valid cycle, never retroactively.
REQ-037 err_count_o SHALL increment by 1 on each registered err_detected and saturate at 16'hFFFF.

Reset
REQ-038 When rst=1 at a clock edge, all counters, is_broken_o, voted_o, valid_o, the error flags and err_count_o SHALL become 0, so mode_o becomes NMR.
REQ-039 rst SHALL override valid_i, set_broken_i and clr_broken_i.
REQ-040 Reset mid-stream SHALL drop any in-flight result, so valid_o=0 in the cycle after reset.

Configuration
REQ-041 The feature macro SHALL be named CV32E40P_FT_ERR_COUNTER_EN.
REQ-042 With CV32E40P_FT_ERR_COUNTER_EN defined, the err_count_o logic SHALL be present.
REQ-043 Without CV32E40P_FT_ERR_COUNTER_EN, err_count_o SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-044 The shared package cv32e40p_pkg2_ft SHALL hold the voter_mode_e enum (NMR, DUPLEX, SIMPLEX, FAILED) and the default INCREMENT, DECREMENT, BREAKING_THRESHOLD and COUNT_BIT constants.
REQ-045 Each replica's counter and sticky flag SHALL be a sub-module, cv32e40p_breakage_counter, instantiated N_REP times.
REQ-046 The vote and blame logic SHALL remain in the top module.

Verification
REQ-047 N_REP=3, all replicas 0xA5A5A5A5, valid -> next cycle voted_o=0xA5A5A5A5, valid_o=1, all error flags 0.
REQ-048 Replica 1 = 0x0 and others 0x1234 for 4 valid cycles -> voted_o=0x1234, err_corrected=1 each cycle; is_broken_o=3'b010 after the 4th (counter 12); then mode_o=DUPLEX.
REQ-049 DUPLEX with replicas 0 and 2 at 0x10 and 0x11 -> voted_o=0x10, uncorrectable_o=1, and both counters are unchanged.
REQ-050 N_REP=5 with replicas {7,7,9,9,3} -> no majority, voted_o=7, uncorrectable_o=1.
REQ-051 set_broken_i=3'b111 -> mode_o=FAILED and voted_o=0; then clr_broken_i[0] and set_broken_i[0] in the same cycle -> replica 0 healthy and mode_o=SIMPLEX.
REQ-052 rst asserted while valid_o=1 and err_count_o=5 -> next cycle valid_o=0, err_count_o=0, is_broken_o=0.

Source files
------------

// File: rtl/cv32e40p_nmr_voter_ctrl_pkg.sv
// Shared fault-tolerance types and default breakage-counter constants for the NMR voter.
package cv32e40p_pkg2_ft;

  typedef enum logic [1:0] {
    NMR     = 2'd0,
    DUPLEX  = 2'd1,
    SIMPLEX = 2'd2,
    FAILED  = 2'd3
  } voter_mode_e;

  localparam int DEFAULT_INCREMENT          = 32'sd3;
  localparam int DEFAULT_DECREMENT          = 32'sd1;
  localparam int DEFAULT_BREAKING_THRESHOLD = 32'sd12;
  localparam int DEFAULT_COUNT_BIT          = 32'sd5;

endpackage

// File: rtl/cv32e40p_breakage_counter.sv
// Per-replica saturating blame counter with a sticky broken flag.
module cv32e40p_breakage_counter #(
  parameter int INCREMENT          = 3,
  parameter int DECREMENT          = 1,
  parameter int BREAKING_THRESHOLD = 12,
  parameter int COUNT_BIT          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic blame_i,
  input  logic set_i,
  input  logic clr_i,
  output logic broken_o
);

  localparam int unsigned MAX_CNT = (32'd1 << COUNT_BIT) - 32'd1;

  logic [COUNT_BIT-1:0] count_r;
  logic                 broken_r;
  int unsigned          cnt_cur_s;
  int unsigned          cnt_next_s;
  logic                 thresh_hit_s;

  // Next counter value: saturating add on blame, saturating subtract on a clean valid cycle.
  always_comb begin
    cnt_cur_s  = 32'(count_r);
    cnt_next_s = cnt_cur_s;
    if (valid_i && blame_i) begin
      cnt_next_s = (cnt_cur_s + 32'(INCREMENT) > MAX_CNT) ? MAX_CNT : cnt_cur_s + 32'(INCREMENT);
    end else if (valid_i) begin
      cnt_next_s = (cnt_cur_s < 32'(DECREMENT)) ? 32'd0 : cnt_cur_s - 32'(DECREMENT);
    end else begin
      cnt_next_s = cnt_cur_s;
    end
    thresh_hit_s = (cnt_next_s >= 32'(BREAKING_THRESHOLD));
  end

  // Counter and sticky flag; clear wins over set and increment, a broken replica freezes.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_r  <= '0;
      broken_r <= 1'b0;
    end else if (broken_r) begin
      count_r  <= count_r;
      broken_r <= 1'b1;
    end else begin
      count_r  <= COUNT_BIT'(cnt_next_s);
      broken_r <= set_i || thresh_hit_s;
    end
  end

  assign broken_o = broken_r;

endmodule

// File: rtl/cv32e40p_nmr_voter_ctrl.sv
// N-modular-redundancy voter with graceful degradation (NMR/DUPLEX/SIMPLEX/FAILED).
// Optional error-event counter enabled by macro CV32E40P_FT_ERR_COUNTER_EN.
module cv32e40p_nmr_voter_ctrl
  import cv32e40p_pkg2_ft::*;
#(
  parameter int N_REP              = 3,
  parameter int WIDTH              = 32,
  parameter int INCREMENT          = DEFAULT_INCREMENT,
  parameter int DECREMENT          = DEFAULT_DECREMENT,
  parameter int BREAKING_THRESHOLD = DEFAULT_BREAKING_THRESHOLD,
  parameter int COUNT_BIT          = DEFAULT_COUNT_BIT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic [N_REP-1:0][WIDTH-1:0] rep_data_i,
  input  logic [N_REP-1:0]            set_broken_i,
  input  logic [N_REP-1:0]            clr_broken_i,
  output logic [WIDTH-1:0]            voted_o,
  output logic                        valid_o,
  output logic                        err_detected_o,
  output logic                        err_corrected_o,
  output logic                        uncorrectable_o,
  output logic [N_REP-1:0]            is_broken_o,
  output logic [1:0]                  mode_o,
  output logic [15:0]                 err_count_o
);

  if (N_REP != 3 && N_REP != 5) begin : g_bad_nrep
    $error("cv32e40p_nmr_voter_ctrl: N_REP must be 3 or 5");
  end

  logic [N_REP-1:0] is_broken_s, healthy_s, blame_s, diff_s;
  logic [7:0]       h_cnt_s, match_cnt_s;
  voter_mode_e      mode_s;
  logic [WIDTH-1:0] ref_s, maj_val_s, vote_s, voted_r;
  logic             maj_found_s, det_s, cor_s, unc_s;
  logic             valid_r, det_r, cor_r, unc_r;

  for (genvar k = 0; k < N_REP; k++) begin : g_rep
    cv32e40p_breakage_counter #(
      .INCREMENT(INCREMENT), .DECREMENT(DECREMENT),
      .BREAKING_THRESHOLD(BREAKING_THRESHOLD), .COUNT_BIT(COUNT_BIT)
    ) u_cnt (
      .clk(clk), .rst(rst), .valid_i(valid_i), .blame_i(blame_s[k]),
      .set_i(set_broken_i[k]), .clr_i(clr_broken_i[k]), .broken_o(is_broken_s[k])
    );
  end

  assign healthy_s = ~is_broken_s;

  // Healthy-replica count selects the degradation mode.
  always_comb begin
    h_cnt_s = 8'd0;
    for (int k = 0; k < N_REP; k++) h_cnt_s = h_cnt_s + {7'd0, healthy_s[k]};
    if (h_cnt_s >= 8'd3)      mode_s = NMR;
    else if (h_cnt_s == 8'd2) mode_s = DUPLEX;
    else if (h_cnt_s == 8'd1) mode_s = SIMPLEX;
    else                      mode_s = FAILED;
  end

  // Reference (lowest healthy), strict majority among healthy replicas, and per-replica disagreement.
  always_comb begin
    ref_s       = '0;
    maj_found_s = 1'b0;
    maj_val_s   = '0;
    match_cnt_s = 8'd0;
    diff_s      = '0;
    for (int k = N_REP - 1; k >= 0; k--) ref_s = healthy_s[k] ? rep_data_i[k] : ref_s;
    for (int i = 0; i < N_REP; i++) begin
      match_cnt_s = 8'd0;
      for (int j = 0; j < N_REP; j++) begin
        match_cnt_s = match_cnt_s +
          ((healthy_s[i] && healthy_s[j] && rep_data_i[i] == rep_data_i[j]) ? 8'd1 : 8'd0);
      end
      if (!maj_found_s && ((match_cnt_s << 1) > h_cnt_s)) begin
        maj_found_s = 1'b1;
        maj_val_s   = rep_data_i[i];
      end else begin
        maj_found_s = maj_found_s;
        maj_val_s   = maj_val_s;
      end
    end
    for (int k = 0; k < N_REP; k++) begin
      diff_s[k] = healthy_s[k] && (rep_data_i[k] != (maj_found_s ? maj_val_s : ref_s));
    end
  end

  // Mode-dependent result and flags; only a majority vote in NMR may blame a replica.
  always_comb begin
    vote_s  = '0;
    det_s   = 1'b0;
    cor_s   = 1'b0;
    unc_s   = 1'b0;
    blame_s = '0;
    case (mode_s)
      NMR: begin
        vote_s  = maj_found_s ? maj_val_s : ref_s;
        det_s   = |diff_s;
        cor_s   = maj_found_s && (|diff_s);
        unc_s   = !maj_found_s;
        blame_s = maj_found_s ? diff_s : '0;
      end
      DUPLEX: begin
        vote_s = ref_s;
        det_s  = |diff_s;
        unc_s  = |diff_s;
      end
      SIMPLEX: vote_s = ref_s;
      FAILED: begin
        vote_s = '0;
        unc_s  = 1'b1;
      end
      default: begin
        vote_s = '0;
        unc_s  = 1'b1;
      end
    endcase
  end

  // Output stage: value holds across invalid cycles, flags drop to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      voted_r <= '0;
      valid_r <= 1'b0;
      det_r   <= 1'b0;
      cor_r   <= 1'b0;
      unc_r   <= 1'b0;
    end else if (valid_i) begin
      voted_r <= vote_s;
      valid_r <= 1'b1;
      det_r   <= det_s;
      cor_r   <= cor_s;
      unc_r   <= unc_s;
    end else begin
      voted_r <= voted_r;
      valid_r <= 1'b0;
      det_r   <= 1'b0;
      cor_r   <= 1'b0;
      unc_r   <= 1'b0;
    end
  end

`ifdef CV32E40P_FT_ERR_COUNTER_EN
  logic [15:0] err_count_r;

  // Saturating count of registered error detections.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= 16'h0000;
    end else if (det_r && err_count_r != 16'hFFFF) begin
      err_count_r <= err_count_r + 16'h0001;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count_o = err_count_r;
`else
  assign err_count_o = 16'h0000;
`endif

  assign voted_o         = voted_r;
  assign valid_o         = valid_r;
  assign err_detected_o  = det_r;
  assign err_corrected_o = cor_r;
  assign uncorrectable_o = unc_r;
  assign is_broken_o     = is_broken_s;
  assign mode_o          = mode_s;

endmodule

// File: tb/tb_cv32e40p_nmr_voter_ctrl.sv
// Scoreboard bench for the NMR voter: 3-replica instance for the main flow, 5-replica for wide votes.
module tb_cv32e40p_nmr_voter_ctrl;

  typedef struct packed {
    logic        v;
    logic [31:0] voted;
    logic        det;
    logic        cor;
    logic        unc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic             valid3;
  logic [2:0][31:0] rep3;
  logic [2:0]       set3, clr3;
  logic [31:0]      voted3;
  logic             valid_o3, det3, cor3, unc3;
  logic [2:0]       broken3;
  logic [1:0]       mode3;
  logic [15:0]      errcnt3;

  logic             valid5;
  logic [4:0][31:0] rep5;
  logic [4:0]       set5, clr5;
  logic [31:0]      voted5;
  logic             valid_o5, det5, cor5, unc5;
  logic [4:0]       broken5;
  logic [1:0]       mode5;
  logic [15:0]      errcnt5;

  exp_t        sb_q[$];
  logic [31:0] last_voted;
  int          exp_err;
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  cv32e40p_nmr_voter_ctrl #(.N_REP(3), .WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .valid_i(valid3), .rep_data_i(rep3),
    .set_broken_i(set3), .clr_broken_i(clr3), .voted_o(voted3), .valid_o(valid_o3),
    .err_detected_o(det3), .err_corrected_o(cor3), .uncorrectable_o(unc3),
    .is_broken_o(broken3), .mode_o(mode3), .err_count_o(errcnt3)
  );

  cv32e40p_nmr_voter_ctrl #(.N_REP(5), .WIDTH(32)) dut5 (
    .clk(clk), .rst(rst), .valid_i(valid5), .rep_data_i(rep5),
    .set_broken_i(set5), .clr_broken_i(clr5), .voted_o(voted5), .valid_o(valid_o5),
    .err_detected_o(det5), .err_corrected_o(cor5), .uncorrectable_o(unc5),
    .is_broken_o(broken5), .mode_o(mode5), .err_count_o(errcnt5)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle on the 3-replica DUT: push expectation, clock, pop and compare.
  task automatic drive(input logic v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [2:0] set, input logic [2:0] clr,
                       input logic [31:0] ev, input logic ed, input logic ec, input logic eu);
    exp_t e;
    valid3 = v;
    rep3   = {d2, d1, d0};
    set3   = set;
    clr3   = clr;
    e.v     = v;
    e.voted = v ? ev : last_voted;
    e.det   = v & ed;
    e.cor   = v & ec;
    e.unc   = v & eu;
    last_voted = e.voted;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    set3   = 3'b000;
    clr3   = 3'b000;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("valid_o", {31'd0, valid_o3}, {31'd0, e.v});
      chk("voted_o", voted3, e.voted);
      chk("err_det", {31'd0, det3}, {31'd0, e.det});
      chk("err_cor", {31'd0, cor3}, {31'd0, e.cor});
      chk("uncorr", {31'd0, unc3}, {31'd0, e.unc});
      chk("err_count", {16'd0, errcnt3}, 32'(exp_err));
`ifdef CV32E40P_FT_ERR_COUNTER_EN
      if (e.det && exp_err < 32'sd65535) exp_err++;
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    valid3 = 1'b0; rep3 = '0; set3 = '0; clr3 = '0;
    valid5 = 1'b0; rep5 = '0; set5 = '0; clr5 = '0;
    last_voted = 32'd0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", {31'd0, valid_o3}, 32'd0);
    chk("rst_voted", voted3, 32'd0);
    chk("rst_broken", {29'd0, broken3}, 32'd0);
    chk("rst_mode", {30'd0, mode3}, 32'd0);
    chk("rst_errcnt", {16'd0, errcnt3}, 32'd0);

    // 5 replicas: no majority, then 3-of-5 majority
    valid5 = 1'b1;
    rep5 = {32'd3, 32'd9, 32'd9, 32'd7, 32'd7};
    @(posedge clk); #1;
    chk("n5_nomaj_voted", voted5, 32'd7);
    chk("n5_nomaj_unc", {31'd0, unc5}, 32'd1);
    chk("n5_nomaj_det", {31'd0, det5}, 32'd1);
    chk("n5_nomaj_cor", {31'd0, cor5}, 32'd0);
    rep5 = {32'd2, 32'd1, 32'd5, 32'd5, 32'd5};
    @(posedge clk); #1;
    valid5 = 1'b0;
    chk("n5_maj_voted", voted5, 32'd5);
    chk("n5_maj_cor", {31'd0, cor5}, 32'd1);
    chk("n5_maj_unc", {31'd0, unc5}, 32'd0);
    chk("n5_mode", {30'd0, mode5}, 32'd0);

    // Clean vote, then an invalid cycle holds the value and clears flags
    drive(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b000, 3'b000, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h1, 32'h2, 32'h3, 3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);

    // Replica 1 outvoted four times -> broken, DUPLEX
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1234, 32'h0, 32'h1234, 3'b000, 3'b000, 32'h1234, 1'b1, 1'b1, 1'b0);
      chk("blame_broken", {29'd0, broken3}, (i == 3) ? 32'd2 : 32'd0);
    end
    chk("duplex_mode", {30'd0, mode3}, 32'd1);

    // DUPLEX mismatch: lower index wins, nobody blamed
    drive(1'b1, 32'h10, 32'h55, 32'h11, 3'b000, 3'b000, 32'h10, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h10, 32'h55, 32'h11, 3'b000, 3'b000, 32'h10, 1'b1, 1'b0, 1'b1);
    chk("duplex_noblame", {29'd0, broken3}, 32'd2);
    drive(1'b1, 32'h20, 32'h99, 32'h20, 3'b000, 3'b000, 32'h20, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);

    // Force all broken -> FAILED, then clear+set on replica 0 -> SIMPLEX
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b111, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("failed_mode", {30'd0, mode3}, 32'd3);
    drive(1'b1, 32'h7, 32'h8, 32'h9, 3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b001, 3'b001, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("clrprio_broken", {29'd0, broken3}, 32'd6);
    chk("simplex_mode", {30'd0, mode3}, 32'd2);
    drive(1'b1, 32'h77, 32'h1, 32'h2, 3'b000, 3'b000, 32'h77, 1'b0, 1'b0, 1'b0);

    // New broken flag only affects the following vote
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b111, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("clr_all_mode", {30'd0, mode3}, 32'd0);
    drive(1'b1, 32'h1, 32'h2, 32'h2, 3'b100, 3'b000, 32'h2, 1'b1, 1'b1, 1'b0);
    chk("set_broken2", {29'd0, broken3}, 32'd4);
    drive(1'b1, 32'h1, 32'h2, 32'h2, 3'b000, 3'b000, 32'h1, 1'b1, 1'b0, 1'b1);

    // Counter decrements on clean cycles: 3,6,9 -> 8,7 -> 10,13
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b111, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h5, 32'h5, 32'h6, 3'b000, 3'b000, 32'h5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, 32'h5, 32'h5, 32'h5, 3'b000, 3'b000, 32'h5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h5, 32'h5, 32'h6, 3'b000, 3'b000, 32'h5, 1'b1, 1'b1, 1'b0);
    chk("dec_not_broken", {29'd0, broken3}, 32'd0);
    drive(1'b1, 32'h5, 32'h5, 32'h6, 3'b000, 3'b000, 32'h5, 1'b1, 1'b1, 1'b0);
    chk("dec_broken", {29'd0, broken3}, 32'd4);
    chk("pre_rst_valid", {31'd0, valid_o3}, 32'd1);

    // Reset overrides valid/set while a result is in flight
    rst = 1'b1; valid3 = 1'b1; set3 = 3'b111; rep3 = {32'h1, 32'h2, 32'h3};
    @(posedge clk); #1;
    rst = 1'b0; valid3 = 1'b0; set3 = 3'b000;
    sb_q.delete();
    last_voted = 32'd0;
    exp_err = 0;
    chk("midrst_valid", {31'd0, valid_o3}, 32'd0);
    chk("midrst_voted", voted3, 32'd0);
    chk("midrst_errcnt", {16'd0, errcnt3}, 32'd0);
    chk("midrst_broken", {29'd0, broken3}, 32'd0);
    chk("midrst_mode", {30'd0, mode3}, 32'd0);
    chk("midrst_unc", {31'd0, unc3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
